// File: rtl/brush_paint_ctrl_if.sv
// Request, status and framebuffer write-port bundle for the brush paint controller.
// The master modport is the controller's view; the slave modport is the surrounding logic's view.
interface brush_paint_ctrl_if #(
  parameter int unsigned HPOS_WIDTH = 10,
  parameter int unsigned VPOS_WIDTH = 10,
  parameter int unsigned SIZE_WIDTH = 4
);
  logic                  display_on;
  logic                  paint_req;
  logic                  erase;
  logic                  clear_req;
  logic [HPOS_WIDTH-1:0] cursor_xpos;
  logic [VPOS_WIDTH-1:0] cursor_ypos;
  logic [SIZE_WIDTH-1:0] brush_size;
  logic                  busy;
  logic                  paint_done;
  logic                  fb_we;
  logic [HPOS_WIDTH-1:0] fb_wx;
  logic [VPOS_WIDTH-1:0] fb_wy;
  logic [2:0]            fb_wdata;

  modport master (
    input  display_on, paint_req, erase, clear_req, cursor_xpos, cursor_ypos, brush_size,
    output busy, paint_done, fb_we, fb_wx, fb_wy, fb_wdata
  );

  modport slave (
    output display_on, paint_req, erase, clear_req, cursor_xpos, cursor_ypos, brush_size,
    input  busy, paint_done, fb_we, fb_wx, fb_wy, fb_wdata
  );
endinterface

// File: rtl/brush_paint_ctrl.sv
// Sweeps a clipped square brush stroke, or a full-screen clear, into the framebuffer
// write port, writing only while scan-out is in blanking.
module brush_paint_ctrl #(
  parameter int unsigned HPOS_WIDTH  = 10,
  parameter int unsigned VPOS_WIDTH  = 10,
  parameter int unsigned SIZE_WIDTH  = 4,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter logic [2:0]  BRUSH_COLOR = 3'b101
) (
  input logic                clk,
  input logic                reset_n,
  brush_paint_ctrl_if.master bus
);

  localparam int unsigned XW = HPOS_WIDTH + 1;
  localparam int unsigned YW = VPOS_WIDTH + 1;
  localparam logic signed [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic signed [YW-1:0] YLast = YW'(V_ACTIVE - 1);
  localparam logic [HPOS_WIDTH-1:0] XMax = HPOS_WIDTH'(H_ACTIVE - 1);
  localparam logic [VPOS_WIDTH-1:0] YMax = VPOS_WIDTH'(V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StPaint, StClear, StDone} state_e;

  state_e                state_q, state_d;
  logic [HPOS_WIDTH-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
  logic [VPOS_WIDTH-1:0] y_q, y_d, ymax_q, ymax_d;
  logic [2:0]            data_q, data_d;

  logic signed [XW-1:0] cx_s, sx_s, xlo, xhi, x0, x1;
  logic signed [YW-1:0] cy_s, sy_s, ylo, yhi, y0, y1;
  logic                 empty;
  logic                 write_en;

  // Clip bounds in one extra signed bit so a brush hanging off the left/top edge goes negative.
  always_comb begin
    cx_s  = signed'({1'b0, bus.cursor_xpos});
    sx_s  = signed'(XW'(bus.brush_size));
    cy_s  = signed'({1'b0, bus.cursor_ypos});
    sy_s  = signed'(YW'(bus.brush_size));
    xlo   = cx_s - sx_s;
    xhi   = cx_s + sx_s;
    ylo   = cy_s - sy_s;
    yhi   = cy_s + sy_s;
    x0    = xlo[XW-1] ? '0 : xlo;
    x1    = (xhi > XLast) ? XLast : xhi;
    y0    = ylo[YW-1] ? '0 : ylo;
    y1    = (yhi > YLast) ? YLast : yhi;
    empty = (x0 > x1) || (y0 > y1);
  end

  assign write_en = ((state_q == StPaint) || (state_q == StClear)) && !bus.display_on;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymax_d  = ymax_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.clear_req) begin
          state_d = StClear;
          x_d     = '0;
          y_d     = '0;
          xmin_d  = '0;
          xmax_d  = XMax;
          ymax_d  = YMax;
          data_d  = 3'b000;
        end else if (bus.paint_req) begin
          data_d = bus.erase ? 3'b000 : BRUSH_COLOR;
          if (empty) begin
            state_d = StDone;
          end else begin
            state_d = StPaint;
            x_d     = x0[HPOS_WIDTH-1:0];
            y_d     = y0[VPOS_WIDTH-1:0];
            xmin_d  = x0[HPOS_WIDTH-1:0];
            xmax_d  = x1[HPOS_WIDTH-1:0];
            ymax_d  = y1[VPOS_WIDTH-1:0];
          end
        end
      end
      StPaint, StClear: begin
        // Counters only move on a real write; active video stalls the sweep.
        if (write_en) begin
          if (x_q == xmax_q) begin
            if (y_q == ymax_q) begin
              state_d = StDone;
            end else begin
              x_d = xmin_q;
              y_d = y_q + VPOS_WIDTH'(1);
            end
          end else begin
            x_d = x_q + HPOS_WIDTH'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymax_q  <= '0;
      data_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymax_q  <= ymax_d;
      data_q  <= data_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.paint_done = (state_q == StDone);
  assign bus.fb_we      = write_en;
  assign bus.fb_wx      = x_q;
  assign bus.fb_wy      = y_q;
  assign bus.fb_wdata   = data_q;

endmodule

// File: tb/tb_brush_paint_ctrl.sv
// Self-checking bench for brush_paint_ctrl: directed vector table, hand sequences for
// stalls, request collisions and reset, plus random strokes against a pixel-list model.
module tb_brush_paint_ctrl;

  localparam int H = 160;
  localparam int V = 120;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  brush_paint_ctrl_if #(.HPOS_WIDTH(10), .VPOS_WIDTH(10), .SIZE_WIDTH(4)) bus ();

  brush_paint_ctrl #(
    .HPOS_WIDTH(10), .VPOS_WIDTH(10), .SIZE_WIDTH(4),
    .H_ACTIVE(H), .V_ACTIVE(V), .BRUSH_COLOR(3'b101)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {int x; int y; int d; int c;} wr_t;
  typedef struct {int cx; int cy; int sz; int er; int n; int fx; int fy; int lx; int ly; int d;} vec_t;

  wr_t  wr_q[$];
  wr_t  exp_q[$];
  vec_t vecs[8];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int disp_mode = 0;
  int pat_i = 0;
  bit prev_busy = 0;
  bit prev_disp = 0;
  int prev_x = 0;
  int prev_y = 0;
  bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Observer: records every write, checks writes never collide with active video,
  // and that coordinates hold across a stalled cycle.
  always @(negedge clk) begin
    wr_t w;
    if (bus.fb_we === 1'b1) begin
      w.x = int'(bus.fb_wx);
      w.y = int'(bus.fb_wy);
      w.d = int'(bus.fb_wdata);
      w.c = cyc;
      wr_q.push_back(w);
      chk("we_in_active_video", int'(bus.display_on), 0);
    end
    if (bus.paint_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_busy && prev_disp && bus.busy === 1'b1)
      chk("stall_hold", int'(bus.fb_wx == 10'(prev_x) && bus.fb_wy == 10'(prev_y)), 1);
    prev_busy = (bus.busy === 1'b1);
    prev_disp = (bus.display_on === 1'b1);
    prev_x    = int'(bus.fb_wx);
    prev_y    = int'(bus.fb_wy);
  end

  initial begin
    bus.display_on = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (disp_mode)
        1: begin
          bus.display_on = pat[pat_i];
          pat_i = (pat_i + 1) % 5;
        end
        2:       bus.display_on = 1'($urandom_range(0, 1));
        default: bus.display_on = 1'b0;
      endcase
    end
  end

  // Expected write list: every on-screen pixel of the square, row-major.
  function automatic void model(input int cx, input int cy, input int sz, input int er,
                                input int clr);
    int  x0, x1, y0, y1;
    wr_t w;
    exp_q.delete();
    if (clr != 0) begin
      x0 = 0; x1 = H - 1; y0 = 0; y1 = V - 1;
    end else begin
      x0 = (cx - sz < 0) ? 0 : cx - sz;
      x1 = (cx + sz > H - 1) ? H - 1 : cx + sz;
      y0 = (cy - sz < 0) ? 0 : cy - sz;
      y1 = (cy + sz > V - 1) ? V - 1 : cy + sz;
    end
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        w.x = x;
        w.y = y;
        w.d = (clr != 0 || er != 0) ? 0 : 5;
        w.c = 0;
        exp_q.push_back(w);
      end
    end
  endfunction

  task automatic issue(input int cx, input int cy, input int sz, input int er, input int preq,
                       input int creq, output int t0);
    wr_q.delete();
    done_cnt = 0;
    @(negedge clk);
    #1;
    bus.cursor_xpos = 10'(cx);
    bus.cursor_ypos = 10'(cy);
    bus.brush_size  = 4'(sz);
    bus.erase       = 1'(er);
    bus.paint_req   = 1'(preq);
    bus.clear_req   = 1'(creq);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.paint_req   = 1'b0;
    bus.clear_req   = 1'b0;
    // Operands must already be latched; scramble them.
    bus.cursor_xpos = 10'($urandom);
    bus.cursor_ypos = 10'($urandom);
    bus.brush_size  = 4'($urandom);
    bus.erase       = 1'($urandom);
  endtask

  task automatic cmp_model(input string nm);
    int bad = -1;
    int n;
    chk({nm, "_count"}, wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && (wr_q[i].x != exp_q[i].x || wr_q[i].y != exp_q[i].y ||
                      wr_q[i].d != exp_q[i].d))
        bad = i;
    end
    if (bad >= 0)
      $display("  %s write #%0d is (%0d,%0d,%0d), model has (%0d,%0d,%0d)", nm, bad,
               wr_q[bad].x, wr_q[bad].y, wr_q[bad].d, exp_q[bad].x, exp_q[bad].y, exp_q[bad].d);
    chk({nm, "_first_bad_write"}, bad, -1);
  endtask

  task automatic finish_op(input string nm, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_busy_after_done"}, int'(bus.busy), 0);
    cmp_model(nm);
  endtask

  initial begin
    int t0;
    string nm;

    bus.paint_req = 0; bus.clear_req = 0; bus.erase = 0;
    bus.cursor_xpos = 0; bus.cursor_ypos = 0; bus.brush_size = 0;

    vecs[0] = '{100, 50, 2, 0, 25, 98, 48, 102, 52, 5};
    vecs[1] = '{0, 0, 3, 0, 16, 0, 0, 3, 3, 5};
    vecs[2] = '{159, 119, 1, 0, 4, 158, 118, 159, 119, 5};
    vecs[3] = '{20, 20, 0, 1, 1, 20, 20, 20, 20, 0};
    vecs[4] = '{700, 10, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{5, 118, 4, 0, 54, 1, 114, 9, 119, 5};
    vecs[6] = '{1023, 1023, 15, 0, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{159, 60, 15, 0, 496, 144, 45, 159, 75, 5};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.paint_done), 0);
    chk("rst_we", int'(bus.fb_we), 0);
    chk("rst_wx", int'(bus.fb_wx), 0);
    chk("rst_wy", int'(bus.fb_wy), 0);
    chk("rst_wdata", int'(bus.fb_wdata), 0);
    reset_n = 1'b1;

    // Directed vectors, no stalls.
    for (int i = 0; i < 8; i++) begin
      nm = $sformatf("vec%0d", i);
      model(vecs[i].cx, vecs[i].cy, vecs[i].sz, vecs[i].er, 0);
      issue(vecs[i].cx, vecs[i].cy, vecs[i].sz, vecs[i].er, 1, 0, t0);
      finish_op(nm, 2000);
      chk({nm, "_n"}, wr_q.size(), vecs[i].n);
      chk({nm, "_done_latency"}, done_cyc - t0, vecs[i].n);
      if (wr_q.size() > 0 && vecs[i].n > 0) begin
        chk({nm, "_first_x"}, wr_q[0].x, vecs[i].fx);
        chk({nm, "_first_y"}, wr_q[0].y, vecs[i].fy);
        chk({nm, "_last_x"}, wr_q[wr_q.size()-1].x, vecs[i].lx);
        chk({nm, "_last_y"}, wr_q[wr_q.size()-1].y, vecs[i].ly);
        chk({nm, "_data"}, wr_q[0].d, vecs[i].d);
        chk({nm, "_first_latency"}, wr_q[0].c - t0, 0);
        chk({nm, "_back_to_back"}, wr_q[wr_q.size()-1].c - wr_q[0].c, vecs[i].n - 1);
      end
    end

    // Stalls from a fixed display_on pattern.
    disp_mode = 1;
    pat_i = 0;
    model(10, 10, 1, 0, 0);
    issue(10, 10, 1, 0, 1, 0, t0);
    finish_op("stall", 200);
    disp_mode = 0;

    // Requests while busy are dropped.
    model(50, 50, 1, 0, 0);
    issue(50, 50, 1, 0, 1, 0, t0);
    for (int i = 0; i < 50 && wr_q.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    bus.paint_req = 1'b1;
    bus.clear_req = 1'b1;
    bus.cursor_xpos = 10'd5;
    bus.cursor_ypos = 10'd5;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.paint_req = 1'b0;
    bus.clear_req = 1'b0;
    finish_op("busy_req", 200);

    // Clear wins over a simultaneous paint.
    model(0, 0, 0, 0, 1);
    issue(30, 30, 2, 0, 1, 1, t0);
    finish_op("clear", 25000);
    chk("clear_done_latency", done_cyc - t0, H * V);
    repeat (5) @(negedge clk);
    #1;
    chk("clear_no_paint_after", wr_q.size(), H * V);
    chk("clear_idle_after", int'(bus.busy), 0);

    // Reset mid-stroke abandons the sweep.
    issue(30, 40, 2, 0, 1, 0, t0);
    for (int i = 0; i < 50 && wr_q.size() < 5; i++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_mid_writes", wr_q.size(), 5);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_we", int'(bus.fb_we), 0);
    chk("rst_mid_wx", int'(bus.fb_wx), 0);
    chk("rst_mid_wy", int'(bus.fb_wy), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mid_stays_idle", int'(bus.busy), 0);
    model(5, 6, 1, 0, 0);
    issue(5, 6, 1, 0, 1, 0, t0);
    finish_op("after_rst", 200);
    chk("after_rst_first_latency", (wr_q.size() > 0) ? wr_q[0].c - t0 : -1, 0);

    // Random strokes with random blanking.
    disp_mode = 2;
    for (int k = 0; k < 30; k++) begin
      int cx, cy, sz, er;
      cx = $urandom_range(0, 200);
      cy = $urandom_range(0, 150);
      sz = $urandom_range(0, 10);
      er = $urandom_range(0, 1);
      model(cx, cy, sz, er, 0);
      issue(cx, cy, sz, er, 1, 0, t0);
      finish_op($sformatf("rnd%0d", k), 3000);
    end
    disp_mode = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
